poly_note_allocator: RTL and testbench

//  Parametrised polyphonic successor to the single-note touch decoder.
//  - Debounces N_KEYS touch-pad bits and applies an octave offset.
//  - Allocates pressed keys to N_VOICES voice slots, stealing the oldest voice when enabled.
//  - Drives per-voice note/gate/trigger to the oscillator/envelope bank.

---
 rtl/poly_note_allocator.sv | 152 +++++++++++++++
 tb/tb_poly_note_allocator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_note_allocator.sv
// Polyphonic touch-key allocator: debounces key pads, queues press/release events
// and assigns them to voice slots with optional oldest-voice stealing.
module poly_note_allocator #(
  parameter int N_KEYS          = 12,
  parameter int N_VOICES        = 4,
  parameter int BASE_NOTE       = 60,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AGE_W           = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [N_KEYS-1:0]     touch_status_in,
  input  logic [2:0]            octave_in,
  input  logic                  steal_en_in,
  output logic [8*N_VOICES-1:0] note_out,
  output logic [N_VOICES-1:0]   gate_out,
  output logic [N_VOICES-1:0]   trigger_out,
  output logic                  dropped_out
);

  localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int KEY_W   = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int VOICE_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  logic [N_KEYS-1:0]  stable, press_pend, rel_pend;
  logic [CNT_W-1:0]   cnt [N_KEYS];
  logic [KEY_W-1:0]   voice_key [N_VOICES];
  logic [AGE_W-1:0]   age [N_VOICES];

  logic [N_KEYS-1:0]  flip, rise, fall, svc_mask, press_clr, rel_clr;
  logic               svc_rel, svc_press;
  logic [KEY_W-1:0]   svc_key;
  logic               free_found, rel_match, alloc, drop;
  logic [VOICE_W-1:0] free_v, rel_v, steal_v, alloc_v;
  logic [AGE_W-1:0]   best_age;
  logic signed [9:0]  oct_ext, note_sum;
  logic [6:0]         note_calc;

  // A key's stable level flips on the cycle its counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    for (int k = 0; k < N_KEYS; k++)
      flip[k] = (touch_status_in[k] != stable[k]) && (cnt[k] == CNT_LAST);
    rise = flip & ~stable;
    fall = flip & stable;
  end

  always_comb begin
    svc_rel   = 1'b0;
    svc_press = 1'b0;
    svc_key   = '0;
    if (|rel_pend) begin
      svc_rel = 1'b1;
      for (int k = N_KEYS - 1; k >= 0; k--)
        if (rel_pend[k]) svc_key = KEY_W'(k);
    end else if (|press_pend) begin
      svc_press = 1'b1;
      for (int k = N_KEYS - 1; k >= 0; k--)
        if (press_pend[k]) svc_key = KEY_W'(k);
    end
    svc_mask  = N_KEYS'(1) << svc_key;
    press_clr = svc_press ? svc_mask : '0;
    rel_clr   = svc_rel ? svc_mask : '0;
  end

  // Descending scans leave the lowest matching index; the steal scan keeps the first maximum.
  always_comb begin
    free_found = 1'b0;
    free_v     = '0;
    rel_match  = 1'b0;
    rel_v      = '0;
    for (int v = N_VOICES - 1; v >= 0; v--) begin
      if (!gate_out[v]) begin
        free_found = 1'b1;
        free_v     = VOICE_W'(v);
      end
      if (gate_out[v] && voice_key[v] == svc_key) begin
        rel_match = 1'b1;
        rel_v     = VOICE_W'(v);
      end
    end
    steal_v  = '0;
    best_age = age[0];
    for (int v = 1; v < N_VOICES; v++)
      if (age[v] > best_age) begin
        best_age = age[v];
        steal_v  = VOICE_W'(v);
      end
    alloc   = svc_press && (free_found || steal_en_in);
    drop    = svc_press && !alloc;
    alloc_v = free_found ? free_v : steal_v;
  end

  always_comb begin
    oct_ext  = {{7{octave_in[2]}}, octave_in};
    note_sum = 10'(BASE_NOTE) + 10'(svc_key) + (oct_ext <<< 3) + (oct_ext <<< 2);
    if (note_sum < 10'sd0)        note_calc = 7'd0;
    else if (note_sum > 10'sd127) note_calc = 7'd127;
    else                          note_calc = note_sum[6:0];
  end

  // A fall that lands while its press is still queued cancels both; a press being
  // serviced on that same edge has already taken a voice, so its release must be queued.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stable      <= '0;
      press_pend  <= '0;
      rel_pend    <= '0;
      note_out    <= '0;
      gate_out    <= '0;
      trigger_out <= '0;
      dropped_out <= 1'b0;
      for (int k = 0; k < N_KEYS; k++) cnt[k] <= '0;
      for (int v = 0; v < N_VOICES; v++) begin
        voice_key[v] <= '0;
        age[v]       <= '0;
      end
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (touch_status_in[k] != stable[k]) begin
          if (cnt[k] == CNT_LAST) begin
            stable[k] <= ~stable[k];
            cnt[k]    <= '0;
          end else begin
            cnt[k] <= cnt[k] + CNT_W'(1);
          end
        end else begin
          cnt[k] <= '0;
        end
      end
      press_pend  <= (press_pend | rise) & ~fall & ~press_clr;
      rel_pend    <= (rel_pend | (fall & ~(press_pend & ~press_clr))) & ~rel_clr;
      trigger_out <= '0;
      dropped_out <= drop;
      for (int v = 0; v < N_VOICES; v++) begin
        if (alloc && alloc_v == VOICE_W'(v)) begin
          voice_key[v]       <= svc_key;
          note_out[8*v +: 8] <= {1'b0, note_calc};
          gate_out[v]        <= 1'b1;
          trigger_out[v]     <= 1'b1;
          age[v]             <= '0;
        end else if (alloc && gate_out[v] && age[v] != AGE_MAX) begin
          age[v] <= age[v] + AGE_W'(1);
        end
        if (svc_rel && rel_match && rel_v == VOICE_W'(v))
          gate_out[v] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_poly_note_allocator.sv
// Scoreboard bench for poly_note_allocator: directed key sequences queue expected
// trigger/drop events; a negedge monitor pops and compares them as the DUT emits them.
module tb_poly_note_allocator;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [11:0] touch;
  logic [2:0]  octave;
  logic        steal_en;
  logic [31:0] note_out, hi_note;
  logic [3:0]  gate_out, trigger_out, hi_gate, hi_trig;
  logic        dropped_out, hi_drop;

  always #5 clk_in = ~clk_in;

  poly_note_allocator #(
    .N_KEYS(12), .N_VOICES(4), .BASE_NOTE(60), .DEBOUNCE_CYCLES(16), .AGE_W(4)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .touch_status_in(touch), .octave_in(octave),
    .steal_en_in(steal_en), .note_out(note_out), .gate_out(gate_out),
    .trigger_out(trigger_out), .dropped_out(dropped_out)
  );

  // Same stimulus, high base note, so allocation mirrors dut but notes hit the top clamp.
  poly_note_allocator #(
    .N_KEYS(12), .N_VOICES(4), .BASE_NOTE(120), .DEBOUNCE_CYCLES(16), .AGE_W(4)
  ) dut_hi (
    .clk_in(clk_in), .rst_in(rst_in), .touch_status_in(touch), .octave_in(octave),
    .steal_en_in(steal_en), .note_out(hi_note), .gate_out(hi_gate),
    .trigger_out(hi_trig), .dropped_out(hi_drop)
  );

  typedef struct {
    bit is_drop;
    int voice;
    int note;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   t_stim = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] t, input logic [2:0] o, input logic s);
    @(negedge clk_in);
    touch    = t;
    octave   = o;
    steal_en = s;
    t_stim   = cyc;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic expectTrig(input int v, input int n, input int c);
    exp_t e;
    e.is_drop = 1'b0;
    e.voice   = v;
    e.note    = n;
    e.cyc     = c;
    sb.push_back(e);
  endtask

  task automatic expectDrop(input int c);
    exp_t e;
    e.is_drop = 1'b1;
    e.voice   = 0;
    e.note    = 0;
    e.cyc     = c;
    sb.push_back(e);
  endtask

  // Monitor: every trigger or drop pulse must match the head of the scoreboard.
  always @(negedge clk_in) begin
    for (int v = 0; v < 4; v++) begin
      if (trigger_out[v] === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_trigger_voice", v, 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("trig_kind", 0, mon_e.is_drop);
          checkOutput("trig_voice", v, mon_e.voice);
          checkOutput("trig_note", note_out[8*v +: 8], mon_e.note);
          checkOutput("trig_cycle", cyc, mon_e.cyc);
          checkOutput("trig_gate", gate_out[v], 1);
        end
      end
    end
    if (dropped_out === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_drop", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("drop_kind", 1, mon_e.is_drop);
        checkOutput("drop_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    rst_in   = 1'b1;
    touch    = '0;
    octave   = '0;
    steal_en = 1'b1;
    waitCycles(3);
    checkOutput("reset_gate", gate_out, 0);
    checkOutput("reset_note", note_out, 0);
    checkOutput("reset_trig", trigger_out, 0);
    checkOutput("reset_drop", dropped_out, 0);
    rst_in = 1'b0;

    // 10-cycle touch is shorter than the debounce window.
    applyStimulus(12'h001, 3'd0, 1'b1);
    waitCycles(9);
    applyStimulus(12'h000, 3'd0, 1'b1);
    waitCycles(30);
    checkOutput("glitch_gate", gate_out, 0);

    // Single key 4, exact press and release latency.
    applyStimulus(12'h010, 3'd0, 1'b1);
    expectTrig(0, 64, t_stim + 17);
    waitCycles(16);
    checkOutput("press_gate_early", gate_out[0], 0);
    waitCycles(1);
    checkOutput("press_gate", gate_out, 4'b0001);
    checkOutput("press_note", note_out[7:0], 64);
    waitCycles(5);
    applyStimulus(12'h000, 3'd0, 1'b1);
    waitCycles(16);
    checkOutput("rel_gate_early", gate_out[0], 1);
    waitCycles(1);
    checkOutput("rel_gate", gate_out[0], 0);
    checkOutput("rel_note_hold", note_out[7:0], 64);
    waitCycles(5);

    // Keys 0,1,2 together, serviced on consecutive cycles.
    applyStimulus(12'h007, 3'd0, 1'b1);
    expectTrig(0, 60, t_stim + 17);
    expectTrig(1, 61, t_stim + 18);
    expectTrig(2, 62, t_stim + 19);
    waitCycles(22);
    checkOutput("multi_gate", gate_out, 4'b0111);

    applyStimulus(12'h00F, 3'd0, 1'b1);
    expectTrig(3, 63, t_stim + 17);
    waitCycles(20);
    checkOutput("full_gate", gate_out, 4'b1111);

    // Steal the oldest voice (key 0 on voice 0) for key 7.
    applyStimulus(12'h08F, 3'd0, 1'b1);
    expectTrig(0, 67, t_stim + 17);
    waitCycles(20);
    checkOutput("steal_gate", gate_out, 4'b1111);
    checkOutput("steal_note", note_out[7:0], 67);
    applyStimulus(12'h08E, 3'd0, 1'b1);
    waitCycles(20);
    checkOutput("stolen_release_gate", gate_out, 4'b1111);

    // All busy with stealing off: key 8 is dropped.
    applyStimulus(12'h18E, 3'd0, 1'b0);
    expectDrop(t_stim + 17);
    waitCycles(20);
    checkOutput("drop_gate", gate_out, 4'b1111);
    checkOutput("drop_notes", note_out, 32'h3F3E3D43);

    applyStimulus(12'h000, 3'd0, 1'b1);
    waitCycles(25);
    checkOutput("all_released", gate_out, 0);

    // Octave +3 with key 11, then octave -4 with key 0.
    applyStimulus(12'h800, 3'b011, 1'b1);
    expectTrig(0, 107, t_stim + 17);
    waitCycles(17);
    checkOutput("clamp_note_hi", hi_note[7:0], 127);
    checkOutput("hi_gate", hi_gate, 4'b0001);
    applyStimulus(12'h801, 3'b100, 1'b1);
    expectTrig(1, 12, t_stim + 17);
    waitCycles(17);
    checkOutput("neg_oct_hi", hi_note[15:8], 72);
    checkOutput("latched_note", note_out[7:0], 107);

    // Reset while both voices are sounding.
    waitCycles(3);
    rst_in = 1'b1;
    waitCycles(1);
    checkOutput("midreset_gate", gate_out, 0);
    checkOutput("midreset_note", note_out, 0);
    checkOutput("midreset_trig", trigger_out, 0);
    checkOutput("midreset_hi_gate", hi_gate, 0);
    touch = '0;
    waitCycles(2);
    rst_in = 1'b0;
    waitCycles(20);
    checkOutput("post_reset_gate", gate_out, 0);

    waitCycles(5);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
